// File: rtl/axil_arb_pkg.sv
// ----------------------------------------------------------------------------
// axil_arb_pkg
// Shared types and constants for the 2:1 AXI4-Lite arbiter.
//   arb_state_e : arbiter FSM states
//   arb_kind_e  : transaction kind (read/write) used for intra-port fairness
//   port_idx_t  : upstream port index (0 = PS master, 1 = fabric master)
//   RESP_*      : AXI response encodings
// ----------------------------------------------------------------------------
package axil_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WRESP,
        ST_RD,
        ST_RDATA
    } arb_state_e;

    typedef enum logic {
        KIND_RD = 1'b0,
        KIND_WR = 1'b1
    } arb_kind_e;

    typedef logic [0:0] port_idx_t;

    localparam port_idx_t PORT0 = 1'b0;
    localparam port_idx_t PORT1 = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_arb_2to1_if.sv
// ----------------------------------------------------------------------------
// axil_arb_2to1_if
// AXI4-Lite channel bundle (AW, W, B, AR, R) used for both upstream ports
// and the downstream register-file port of the arbiter.
//   master modport : drives AW/W/AR payload+valid, B/R ready
//   slave  modport : drives AW/W/AR ready, B/R payload+valid
// Parameters: ADDR_W (address width), DATA_W (data width, strobe = DATA_W/8)
// ----------------------------------------------------------------------------
interface axil_arb_2to1_if #(
    parameter int unsigned ADDR_W = 40,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input  awready,
        output wdata, wstrb, wvalid,    input  wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input  arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input  rready
    );

endinterface

// File: rtl/axil_arb_2to1_rr_pick.sv
// ----------------------------------------------------------------------------
// axil_arb_rr_pick
// Combinational grant picker for the 2:1 arbiter.
//   i_wr_req[N]   : port N requests a write (AW or W valid)
//   i_rd_req[N]   : port N requests a read  (AR valid)
//   i_last_port   : port that completed the previous transaction
//   i_last_kind[N]: kind of port N's previous transaction (1 = write)
//   o_valid       : some port is requesting
//   o_port/o_kind : chosen port and transaction kind
// Port search starts after i_last_port; a port with both kinds pending takes
// the kind opposite to its previous one.
// ----------------------------------------------------------------------------
module axil_arb_rr_pick
    import axil_arb_pkg::*;
(
    input  logic [1:0] i_wr_req,
    input  logic [1:0] i_rd_req,
    input  port_idx_t  i_last_port,
    input  logic [1:0] i_last_kind,
    output logic       o_valid,
    output port_idx_t  o_port,
    output arb_kind_e  o_kind
);

    port_idx_t w_first;

    always_comb begin
        w_first = ~i_last_port;
        o_valid = |{i_wr_req, i_rd_req};
        o_kind  = KIND_RD;

        if (i_wr_req[w_first] | i_rd_req[w_first]) begin
            o_port = w_first;
        end else begin
            o_port = i_last_port;
        end

        if (i_wr_req[o_port] & i_rd_req[o_port]) begin
            o_kind = (i_last_kind[o_port] == KIND_WR) ? KIND_RD : KIND_WR;
        end else if (i_wr_req[o_port]) begin
            o_kind = KIND_WR;
        end
    end

endmodule

// File: rtl/axil_arb_2to1.sv
// ----------------------------------------------------------------------------
// axil_arb_2to1
// Two-to-one AXI4-Lite arbiter sharing the register-file slave between the
// PS master (s0) and an on-fabric master (s1). One transaction in flight,
// round-robin between ports, write/read alternation within a port.
// Ports:
//   axi_aclk, axi_areset : clock, asynchronous active-high reset
//   s0, s1               : upstream AXI4-Lite ports (slave modport)
//   m                    : downstream port to the register file (master)
//   gnt_cnt0, gnt_cnt1   : completed-transaction counters per port
// Build option: AXIL_ARB_STATS_EN enables the completion counters; when not
// defined the counter outputs are tied to zero.
// ----------------------------------------------------------------------------
module axil_arb_2to1
    import axil_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 40,
    parameter int unsigned DATA_W = 32
) (
    input  logic               axi_aclk,
    input  logic               axi_areset,
    axil_arb_2to1_if.slave     s0,
    axil_arb_2to1_if.slave     s1,
    axil_arb_2to1_if.master    m,
    output logic [15:0]        gnt_cnt0,
    output logic [15:0]        gnt_cnt1
);

    arb_state_e  r_state, w_state_nxt;
    port_idx_t   r_gnt_port, w_gnt_port_nxt;
    logic        r_gnt_is_wr, w_gnt_is_wr_nxt;
    port_idx_t   r_last_port, w_last_port_nxt;
    logic [1:0]  r_last_kind, w_last_kind_nxt;
    logic        r_aw_done, w_aw_done_nxt;
    logic        r_w_done, w_w_done_nxt;

    logic [1:0]  w_wr_req;
    logic [1:0]  w_rd_req;
    logic        w_pick_valid;
    port_idx_t   w_pick_port;
    arb_kind_e   w_pick_kind;

    logic                w_gnt1;
    logic [ADDR_W-1:0]   w_sel_awaddr;
    logic [2:0]          w_sel_awprot;
    logic                w_sel_awvalid;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [DATA_W/8-1:0] w_sel_wstrb;
    logic                w_sel_wvalid;
    logic                w_sel_bready;
    logic [ADDR_W-1:0]   w_sel_araddr;
    logic [2:0]          w_sel_arprot;
    logic                w_sel_arvalid;
    logic                w_sel_rready;

    logic                w_up_awready;
    logic                w_up_wready;
    logic                w_up_arready;
    logic                w_up_bvalid;
    logic [1:0]          w_up_bresp;
    logic                w_up_rvalid;
    logic [DATA_W-1:0]   w_up_rdata;
    logic [1:0]          w_up_rresp;

    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_txn_done;

    // ------------------------------------------------------------------
    // Request decode and grant picker
    // ------------------------------------------------------------------
    assign w_wr_req = {s1.awvalid | s1.wvalid, s0.awvalid | s0.wvalid};
    assign w_rd_req = {s1.arvalid, s0.arvalid};

    axil_arb_rr_pick u_pick (
        .i_wr_req    (w_wr_req),
        .i_rd_req    (w_rd_req),
        .i_last_port (r_last_port),
        .i_last_kind (r_last_kind),
        .o_valid     (w_pick_valid),
        .o_port      (w_pick_port),
        .o_kind      (w_pick_kind)
    );

    // ------------------------------------------------------------------
    // Granted-port request mux
    // ------------------------------------------------------------------
    assign w_gnt1        = (r_gnt_port == PORT1);
    assign w_sel_awaddr  = w_gnt1 ? s1.awaddr  : s0.awaddr;
    assign w_sel_awprot  = w_gnt1 ? s1.awprot  : s0.awprot;
    assign w_sel_awvalid = w_gnt1 ? s1.awvalid : s0.awvalid;
    assign w_sel_wdata   = w_gnt1 ? s1.wdata   : s0.wdata;
    assign w_sel_wstrb   = w_gnt1 ? s1.wstrb   : s0.wstrb;
    assign w_sel_wvalid  = w_gnt1 ? s1.wvalid  : s0.wvalid;
    assign w_sel_bready  = w_gnt1 ? s1.bready  : s0.bready;
    assign w_sel_araddr  = w_gnt1 ? s1.araddr  : s0.araddr;
    assign w_sel_arprot  = w_gnt1 ? s1.arprot  : s0.arprot;
    assign w_sel_arvalid = w_gnt1 ? s1.arvalid : s0.arvalid;
    assign w_sel_rready  = w_gnt1 ? s1.rready  : s0.rready;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            r_state     <= ST_IDLE;
            r_gnt_port  <= PORT0;
            r_gnt_is_wr <= 1'b0;
            r_last_port <= PORT1;
            r_last_kind <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt_port  <= w_gnt_port_nxt;
            r_gnt_is_wr <= w_gnt_is_wr_nxt;
            r_last_port <= w_last_port_nxt;
            r_last_kind <= w_last_kind_nxt;
            r_aw_done   <= w_aw_done_nxt;
            r_w_done    <= w_w_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and channel forwarding
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_port_nxt  = r_gnt_port;
        w_gnt_is_wr_nxt = r_gnt_is_wr;
        w_last_port_nxt = r_last_port;
        w_last_kind_nxt = r_last_kind;
        w_aw_done_nxt   = r_aw_done;
        w_w_done_nxt    = r_w_done;

        w_aw_hs      = 1'b0;
        w_w_hs       = 1'b0;
        w_txn_done   = 1'b0;

        w_up_awready = 1'b0;
        w_up_wready  = 1'b0;
        w_up_arready = 1'b0;
        w_up_bvalid  = 1'b0;
        w_up_bresp   = RESP_OKAY;
        w_up_rvalid  = 1'b0;
        w_up_rdata   = '0;
        w_up_rresp   = RESP_OKAY;

        m.awaddr  = '0;
        m.awprot  = '0;
        m.awvalid = 1'b0;
        m.wdata   = '0;
        m.wstrb   = '0;
        m.wvalid  = 1'b0;
        m.bready  = 1'b0;
        m.araddr  = '0;
        m.arprot  = '0;
        m.arvalid = 1'b0;
        m.rready  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_gnt_port_nxt  = w_pick_port;
                    w_gnt_is_wr_nxt = (w_pick_kind == KIND_WR);
                    w_state_nxt     = (w_pick_kind == KIND_WR) ? ST_WR : ST_RD;
                end
            end

            ST_WR: begin
                // AW and W complete independently; a finished channel has
                // its valid masked so the slave never sees a second beat.
                m.awaddr     = w_sel_awaddr;
                m.awprot     = w_sel_awprot;
                m.awvalid    = w_sel_awvalid & ~r_aw_done;
                m.wdata      = w_sel_wdata;
                m.wstrb      = w_sel_wstrb;
                m.wvalid     = w_sel_wvalid & ~r_w_done;
                w_up_awready = m.awready & ~r_aw_done;
                w_up_wready  = m.wready & ~r_w_done;
                w_aw_hs      = w_sel_awvalid & ~r_aw_done & m.awready;
                w_w_hs       = w_sel_wvalid & ~r_w_done & m.wready;
                w_aw_done_nxt = r_aw_done | w_aw_hs;
                w_w_done_nxt  = r_w_done | w_w_hs;
                if (w_aw_done_nxt & w_w_done_nxt) begin
                    w_state_nxt   = ST_WRESP;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                end
            end

            ST_WRESP: begin
                w_up_bvalid = m.bvalid;
                w_up_bresp  = m.bresp;
                m.bready    = w_sel_bready;
                if (m.bvalid & w_sel_bready) begin
                    w_txn_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_RD: begin
                m.araddr     = w_sel_araddr;
                m.arprot     = w_sel_arprot;
                m.arvalid    = w_sel_arvalid;
                w_up_arready = m.arready;
                if (w_sel_arvalid & m.arready) begin
                    w_state_nxt = ST_RDATA;
                end
            end

            ST_RDATA: begin
                w_up_rvalid = m.rvalid;
                w_up_rdata  = m.rdata;
                w_up_rresp  = m.rresp;
                m.rready    = w_sel_rready;
                if (m.rvalid & w_sel_rready) begin
                    w_txn_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_txn_done) begin
            w_last_port_nxt              = r_gnt_port;
            w_last_kind_nxt[r_gnt_port]  = r_gnt_is_wr;
        end
    end

    // ------------------------------------------------------------------
    // Upstream fan-out: non-granted port sees zeros on every output
    // ------------------------------------------------------------------
    assign s0.awready = ~w_gnt1 & w_up_awready;
    assign s0.wready  = ~w_gnt1 & w_up_wready;
    assign s0.arready = ~w_gnt1 & w_up_arready;
    assign s0.bvalid  = ~w_gnt1 & w_up_bvalid;
    assign s0.bresp   = w_gnt1 ? '0 : w_up_bresp;
    assign s0.rvalid  = ~w_gnt1 & w_up_rvalid;
    assign s0.rdata   = w_gnt1 ? '0 : w_up_rdata;
    assign s0.rresp   = w_gnt1 ? '0 : w_up_rresp;

    assign s1.awready = w_gnt1 & w_up_awready;
    assign s1.wready  = w_gnt1 & w_up_wready;
    assign s1.arready = w_gnt1 & w_up_arready;
    assign s1.bvalid  = w_gnt1 & w_up_bvalid;
    assign s1.bresp   = w_gnt1 ? w_up_bresp : '0;
    assign s1.rvalid  = w_gnt1 & w_up_rvalid;
    assign s1.rdata   = w_gnt1 ? w_up_rdata : '0;
    assign s1.rresp   = w_gnt1 ? w_up_rresp : '0;

    // ------------------------------------------------------------------
    // Completion counters
    // ------------------------------------------------------------------
`ifdef AXIL_ARB_STATS_EN
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_txn_done) begin
            if (r_gnt_port == PORT0) begin
                r_cnt0 <= r_cnt0 + 16'd1;
            end else begin
                r_cnt1 <= r_cnt1 + 16'd1;
            end
        end
    end

    assign gnt_cnt0 = r_cnt0;
    assign gnt_cnt1 = r_cnt1;
`else
    assign gnt_cnt0 = '0;
    assign gnt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_axil_arb_2to1.sv
// ----------------------------------------------------------------------------
// tb_axil_arb_2to1
// Self-checking bench for axil_arb_2to1: directed traffic on both upstream
// ports, a behavioural 16-register slave on the downstream port, and a
// scoreboard of expected completions checked by an independent monitor.
// ----------------------------------------------------------------------------
module tb_axil_arb_2to1;
    import axil_arb_pkg::*;

    localparam int unsigned AW = 40;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_arb_2to1_if #(.ADDR_W(AW), .DATA_W(DW)) s0_if ();
    axil_arb_2to1_if #(.ADDR_W(AW), .DATA_W(DW)) s1_if ();
    axil_arb_2to1_if #(.ADDR_W(AW), .DATA_W(DW)) m_if ();

    logic [15:0] gnt_cnt0;
    logic [15:0] gnt_cnt1;

    axil_arb_2to1 #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .axi_aclk   (clk),
        .axi_areset (rst),
        .s0         (s0_if),
        .s1         (s1_if),
        .m          (m_if),
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         port;
        bit         is_wr;
        logic [1:0] resp;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    exp_t sb_q[$];
    wr_t  wr_q[$];

    task automatic exp_wr(input int p, input logic [AW-1:0] a, input logic [31:0] d, input logic [1:0] resp);
        exp_t e;
        wr_t  w;
        e.port = p; e.is_wr = 1'b1; e.resp = resp; e.data = '0;
        w.addr = a; w.data = d;
        sb_q.push_back(e);
        wr_q.push_back(w);
    endtask

    task automatic exp_rd(input int p, input logic [31:0] d, input logic [1:0] resp);
        exp_t e;
        e.port = p; e.is_wr = 1'b0; e.resp = resp; e.data = d;
        sb_q.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // Register-file model on the downstream port
    // ------------------------------------------------------------------
    logic [31:0]   mem [16];
    logic          sl_aw_pend, sl_w_pend, sl_bvalid, sl_rvalid, sl_rpend;
    logic          sl_stall = 1'b0;
    logic [AW-1:0] sl_awaddr;
    logic [31:0]   sl_wdata, sl_rdata;
    logic [3:0]    sl_wstrb;
    logic [1:0]    sl_bresp, sl_rresp;

    assign m_if.awready = !sl_aw_pend;
    assign m_if.wready  = !sl_w_pend;
    assign m_if.arready = !sl_rvalid && !sl_rpend;
    assign m_if.bvalid  = sl_bvalid;
    assign m_if.bresp   = sl_bresp;
    assign m_if.rvalid  = sl_rvalid;
    assign m_if.rdata   = sl_rdata;
    assign m_if.rresp   = sl_rresp;

    function automatic bit addr_err(input logic [AW-1:0] a);
        return a[AW-1:6] != '0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= (i == 0) ? 32'hdeadbeef : 32'h0;
            sl_aw_pend <= 1'b0; sl_w_pend <= 1'b0; sl_bvalid <= 1'b0;
            sl_rvalid <= 1'b0; sl_rpend <= 1'b0;
            sl_awaddr <= '0; sl_wdata <= '0; sl_wstrb <= '0; sl_rdata <= '0;
            sl_bresp <= 2'b00; sl_rresp <= 2'b00;
        end else begin
            if (m_if.awvalid && m_if.awready) begin
                sl_aw_pend <= 1'b1;
                sl_awaddr  <= m_if.awaddr;
            end
            if (m_if.wvalid && m_if.wready) begin
                sl_w_pend <= 1'b1;
                sl_wdata  <= m_if.wdata;
                sl_wstrb  <= m_if.wstrb;
            end
            if (sl_aw_pend && sl_w_pend && !sl_bvalid) begin
                sl_aw_pend <= 1'b0;
                sl_w_pend  <= 1'b0;
                sl_bvalid  <= 1'b1;
                if (addr_err(sl_awaddr)) begin
                    sl_bresp <= RESP_SLVERR;
                end else begin
                    sl_bresp <= RESP_OKAY;
                    for (int b = 0; b < 4; b++)
                        if (sl_wstrb[b]) mem[sl_awaddr[5:2]][b*8 +: 8] <= sl_wdata[b*8 +: 8];
                end
            end
            if (sl_bvalid && m_if.bready) sl_bvalid <= 1'b0;
            if (m_if.arvalid && m_if.arready) begin
                sl_rdata <= addr_err(m_if.araddr) ? 32'h0 : mem[m_if.araddr[5:2]];
                sl_rresp <= addr_err(m_if.araddr) ? RESP_SLVERR : RESP_OKAY;
                if (sl_stall) sl_rpend <= 1'b1;
                else          sl_rvalid <= 1'b1;
            end
            if (sl_rpend && !sl_stall) begin
                sl_rpend  <= 1'b0;
                sl_rvalid <= 1'b1;
            end
            if (sl_rvalid && m_if.rready) sl_rvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    int m_w_beats  = 0;
    int m_aw_beats = 0;
    bit w_seen_alone = 1'b0;

    task automatic sb_event(input int p, input bit is_wr, input logic [1:0] resp, input logic [31:0] data);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: port %0d kind_wr %0d got a response, required none", p, is_wr);
        end else begin
            e = sb_q.pop_front();
            check("sb_port", p, e.port);
            check("sb_kind", is_wr, e.is_wr);
            check("sb_resp", resp, e.resp);
            if (!is_wr) check("sb_rdata", data, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            wr_t w;
            if (m_if.wvalid && m_if.wready) m_w_beats++;
            if (m_if.awvalid && m_if.awready) m_aw_beats++;
            if (sl_w_pend && !sl_aw_pend) w_seen_alone = 1'b1;
            if (sl_aw_pend && sl_w_pend && !sl_bvalid) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected: addr 0x%0h data 0x%0h, required none", sl_awaddr, sl_wdata);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", sl_awaddr, w.addr);
                    check("wr_data", sl_wdata, w.data);
                end
            end
            if (s0_if.bvalid && s0_if.bready) sb_event(0, 1'b1, s0_if.bresp, 32'h0);
            if (s0_if.rvalid && s0_if.rready) sb_event(0, 1'b0, s0_if.rresp, s0_if.rdata);
            if (s1_if.bvalid && s1_if.bready) sb_event(1, 1'b1, s1_if.bresp, 32'h0);
            if (s1_if.rvalid && s1_if.rready) sb_event(1, 1'b0, s1_if.rresp, s1_if.rdata);
        end
    end

    // ------------------------------------------------------------------
    // Upstream drivers
    // ------------------------------------------------------------------
    task automatic set_aw(input int p, input logic v, input logic [AW-1:0] a);
        if (p == 0) begin s0_if.awvalid = v; s0_if.awaddr = a; s0_if.awprot = '0; end
        else        begin s1_if.awvalid = v; s1_if.awaddr = a; s1_if.awprot = '0; end
    endtask

    task automatic set_w(input int p, input logic v, input logic [31:0] d);
        if (p == 0) begin s0_if.wvalid = v; s0_if.wdata = d; s0_if.wstrb = v ? 4'hF : 4'h0; end
        else        begin s1_if.wvalid = v; s1_if.wdata = d; s1_if.wstrb = v ? 4'hF : 4'h0; end
    endtask

    task automatic set_ar(input int p, input logic v, input logic [AW-1:0] a);
        if (p == 0) begin s0_if.arvalid = v; s0_if.araddr = a; s0_if.arprot = '0; end
        else        begin s1_if.arvalid = v; s1_if.araddr = a; s1_if.arprot = '0; end
    endtask

    // ch: 0 = AW, 1 = W, 2 = AR. Holds valid until the ready seen at the
    // preceding negedge completes the handshake on the next posedge.
    task automatic send(input int p, input int ch, input logic [AW-1:0] a, input logic [31:0] d);
        bit hs = 1'b0;
        int n = 0;
        case (ch)
            0: set_aw(p, 1'b1, a);
            1: set_w(p, 1'b1, d);
            default: set_ar(p, 1'b1, a);
        endcase
        while (!hs && n < 200) begin
            @(negedge clk);
            case (ch)
                0: hs = (p == 0) ? s0_if.awready : s1_if.awready;
                1: hs = (p == 0) ? s0_if.wready  : s1_if.wready;
                default: hs = (p == 0) ? s0_if.arready : s1_if.arready;
            endcase
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL hs_timeout: port %0d channel %0d no ready within 200 cycles", p, ch);
        end
        case (ch)
            0: set_aw(p, 1'b0, '0);
            1: set_w(p, 1'b0, '0);
            default: set_ar(p, 1'b0, '0);
        endcase
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d);
        fork
            send(p, 0, a, 32'h0);
            send(p, 1, '0, d);
        join
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        send(p, 2, a, 32'h0);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || wr_q.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0 || wr_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses and %0d writes outstanding, required 0",
                     sb_q.size(), wr_q.size());
            sb_q.delete();
            wr_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin
        int quiet;
        logic [15:0] exp_c0, exp_c1;

        set_aw(0, 1'b0, '0); set_w(0, 1'b0, '0); set_ar(0, 1'b0, '0);
        set_aw(1, 1'b0, '0); set_w(1, 1'b0, '0); set_ar(1, 1'b0, '0);
        s0_if.bready = 1'b1; s0_if.rready = 1'b1;
        s1_if.bready = 1'b1; s1_if.rready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_s0_out", {s0_if.awready, s0_if.wready, s0_if.arready, s0_if.bvalid,
                             s0_if.rvalid, s0_if.bresp, s0_if.rresp}, '0);
        check("rst_s1_out", {s1_if.awready, s1_if.wready, s1_if.arready, s1_if.bvalid,
                             s1_if.rvalid, s1_if.bresp, s1_if.rresp}, '0);
        check("rst_m_ctrl", {m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready}, '0);
        check("rst_m_awaddr", m_if.awaddr, '0);
        check("rst_m_wdata", m_if.wdata, '0);
        check("rst_s0_rdata", s0_if.rdata, '0);
        check("rst_gnt_cnt", {gnt_cnt0, gnt_cnt1}, '0);
        @(posedge clk);
        #1;

        // s0 single write, s1 idle and quiet
        quiet = 0;
        exp_wr(0, 40'h08, 32'h1, RESP_OKAY);
        fork
            wr(0, 40'h08, 32'h1);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if ({s1_if.awready, s1_if.wready, s1_if.arready, s1_if.bvalid, s1_if.rvalid} != '0)
                    quiet++;
            end
        join
        drain();
        check("s1_quiet_cycles", quiet, 0);

        // Simultaneous reads from both ports after reset: s0 first
        do_reset();
        exp_rd(0, 32'hdeadbeef, RESP_OKAY);
        exp_rd(1, 32'hdeadbeef, RESP_OKAY);
        fork
            rd(0, 40'h00);
            rd(1, 40'h00);
        join
        drain();

        // s0 continuous write + read: W,R,W,R for 20 transactions
        do_reset();
        for (int k = 0; k < 10; k++) begin
            exp_wr(0, 40'h0C, 32'(100 + k), RESP_OKAY);
            exp_rd(0, 32'(100 + k), RESP_OKAY);
        end
        fork
            for (int k = 0; k < 10; k++) wr(0, 40'h0C, 32'(100 + k));
            for (int k = 0; k < 10; k++) rd(0, 40'h0C);
        join
        drain();

        // s1 W leads AW by 3 cycles
        do_reset();
        m_w_beats = 0;
        m_aw_beats = 0;
        w_seen_alone = 1'b0;
        exp_wr(1, 40'h14, 32'h55AA, RESP_OKAY);
        fork
            send(1, 1, '0, 32'h55AA);
            begin
                repeat (3) @(posedge clk);
                #1;
                send(1, 0, 40'h14, 32'h0);
            end
        join
        drain();
        check("w_lead_w_beats", m_w_beats, 1);
        check("w_lead_aw_beats", m_aw_beats, 1);
        check("w_lead_w_first", w_seen_alone, 1);
        exp_rd(1, 32'h55AA, RESP_OKAY);
        rd(1, 40'h14);
        drain();

        // Error responses pass through unchanged
        do_reset();
        exp_wr(1, 40'h100, 32'h77, RESP_SLVERR);
        wr(1, 40'h100, 32'h77);
        drain();
        exp_rd(0, 32'h0, RESP_SLVERR);
        rd(0, 40'h100);
        drain();

        // Reset while in RDATA
        do_reset();
        exp_wr(0, 40'h04, 32'h9, RESP_OKAY);
        wr(0, 40'h04, 32'h9);
        drain();
        sl_stall = 1'b1;
        rd(0, 40'h04);
        @(negedge clk);
        check("rdata_wait_rready", m_if.rready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_valids", {m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready,
                                 s0_if.bvalid, s0_if.rvalid, s1_if.bvalid, s1_if.rvalid,
                                 m_if.bvalid, m_if.rvalid}, '0);
        @(posedge clk);
        #1;
        sl_stall = 1'b0;
        rst = 1'b0;
        exp_rd(0, 32'hdeadbeef, RESP_OKAY);
        exp_rd(1, 32'hdeadbeef, RESP_OKAY);
        fork
            rd(0, 40'h00);
            rd(1, 40'h00);
        join
        drain();

        // Completion counters: 5 on s0, 3 on s1
        do_reset();
        for (int k = 0; k < 3; k++) begin
            exp_wr(0, 40'h20, 32'(k), RESP_OKAY);
            wr(0, 40'h20, 32'(k));
            drain();
        end
        for (int k = 0; k < 2; k++) begin
            exp_rd(0, 32'h2, RESP_OKAY);
            rd(0, 40'h20);
            drain();
        end
        for (int k = 0; k < 2; k++) begin
            exp_wr(1, 40'h24, 32'(k + 7), RESP_OKAY);
            wr(1, 40'h24, 32'(k + 7));
            drain();
        end
        exp_rd(1, 32'h8, RESP_OKAY);
        rd(1, 40'h24);
        drain();
`ifdef AXIL_ARB_STATS_EN
        exp_c0 = 16'd5;
        exp_c1 = 16'd3;
`else
        exp_c0 = 16'd0;
        exp_c1 = 16'd0;
`endif
        check("gnt_cnt0", gnt_cnt0, exp_c0);
        check("gnt_cnt1", gnt_cnt1, exp_c1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
